// File: rtl/alu_pkg.sv
// Shared encodings for the RV32I execute-stage ALU: control selector, funct3 codes
// and the opcodes the ALU decoder needs to tell R-type from I-type.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ALU_FUNCT  = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_ADD    = 2'b10,
        ALU_PASSB  = 2'b11
    } alu_ctl_e;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/rv32_branch_cmp.sv
// Branch condition evaluator: equality plus signed/unsigned less-than, selected by
// the branch funct3. Reserved funct3 codes never take the branch.
module rv32_branch_cmp
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    output logic            flag
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (a == b);
    assign lt_s = ($signed(a) < $signed(b));
    assign lt_u = (a < b);

    always_comb begin
        flag = 1'b0;
        case (funct3)
            F3_BEQ:  flag = eq;
            F3_BNE:  flag = !eq;
            F3_BLT:  flag = lt_s;
            F3_BGE:  flag = !lt_s;
            F3_BLTU: flag = lt_u;
            F3_BGEU: flag = !lt_u;
            default: flag = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32_alu.sv
// RV32I ALU: combinational result and branch flag, plus a registered copy of both
// for pipelined consumers (cleared asynchronously by rst_n).
module rv32_alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] src_A,
    input  logic [XLEN-1:0] src_B,
    input  logic [31:0]     instruction,
    input  logic [1:0]      ALU_control,
    output logic [XLEN-1:0] ALU_result,
    output logic            BranchConditionFlag,
    output logic [XLEN-1:0] ALU_result_q,
    output logic            BranchConditionFlag_q
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] shamt;
    logic       cmp_flag;
    alu_ctl_e   ctl;
    logic       unused_instr_bits;

    assign opcode   = instruction[6:0];
    assign funct3   = instruction[14:12];
    assign funct7b5 = instruction[30];
    assign shamt    = src_B[4:0];
    assign ctl      = alu_ctl_e'(ALU_control);
    assign unused_instr_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

    rv32_branch_cmp u_branch_cmp (
        .a      (src_A),
        .b      (src_B),
        .funct3 (funct3),
        .flag   (cmp_flag)
    );

    always_comb begin
        ALU_result = '0;
        case (ctl)
            ALU_FUNCT: begin
                case (funct3)
                    // Only R-type uses instr[30] to select SUB; for ADDI it is immediate data.
                    F3_ADD:  ALU_result = (opcode == OPC_OP && funct7b5) ? src_A - src_B
                                                                         : src_A + src_B;
                    F3_SLL:  ALU_result = src_A << shamt;
                    F3_SLT:  ALU_result = {{(XLEN-1){1'b0}}, ($signed(src_A) < $signed(src_B))};
                    F3_SLTU: ALU_result = {{(XLEN-1){1'b0}}, (src_A < src_B)};
                    F3_XOR:  ALU_result = src_A ^ src_B;
                    F3_SR:   ALU_result = funct7b5 ? $unsigned($signed(src_A) >>> shamt)
                                                   : src_A >> shamt;
                    F3_OR:   ALU_result = src_A | src_B;
                    F3_AND:  ALU_result = src_A & src_B;
                    default: ALU_result = '0;
                endcase
            end
            ALU_BRANCH: ALU_result = src_A - src_B;
            ALU_ADD:    ALU_result = src_A + src_B;
            ALU_PASSB:  ALU_result = src_B;
            default:    ALU_result = '0;
        endcase
    end

    assign BranchConditionFlag = (ctl == ALU_BRANCH) ? cmp_flag : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_result_q          <= '0;
            BranchConditionFlag_q <= 1'b0;
        end else begin
            ALU_result_q          <= ALU_result;
            BranchConditionFlag_q <= BranchConditionFlag;
        end
    end

endmodule

// File: tb/tb_rv32_alu.sv
// Directed self-checking bench for rv32_alu: combinational ops, branch flags and
// the asynchronously-reset output registers.
module tb_rv32_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] src_A;
    logic [31:0] src_B;
    logic [31:0] instruction;
    logic [1:0]  ALU_control;
    logic [31:0] ALU_result;
    logic        BranchConditionFlag;
    logic [31:0] ALU_result_q;
    logic        BranchConditionFlag_q;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    localparam logic [6:0] R_OP = 7'b0110011;
    localparam logic [6:0] I_OP = 7'b0010011;
    localparam logic [6:0] B_OP = 7'b1100011;

    rv32_alu dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .src_A                 (src_A),
        .src_B                 (src_B),
        .instruction           (instruction),
        .ALU_control           (ALU_control),
        .ALU_result            (ALU_result),
        .BranchConditionFlag   (BranchConditionFlag),
        .ALU_result_q          (ALU_result_q),
        .BranchConditionFlag_q (BranchConditionFlag_q)
    );

    // Clock and reset
    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
    end
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3,
                                             input logic b30);
        logic [31:0] w;
        w        = 32'h0;
        w[6:0]   = opc;
        w[14:12] = f3;
        w[30]    = b30;
        return w;
    endfunction

    // Driver: apply one operation and let combinational outputs settle.
    task automatic drive(input logic [1:0] ctl, input logic [6:0] opc, input logic [2:0] f3,
                         input logic b30, input logic [31:0] a, input logic [31:0] b);
        ALU_control = ctl;
        instruction = mk_instr(opc, f3, b30);
        src_A       = a;
        src_B       = b;
        #1;
    endtask

    task automatic test_reset();
        src_A = '0; src_B = '0; instruction = '0; ALU_control = 2'b00;
        #1;
        n_checks++;
        if (ALU_result_q !== 32'h0) begin
            n_fail++; $display("FAIL reset_result_q: got %h want %h", ALU_result_q, 32'h0);
        end
        n_checks++;
        if (BranchConditionFlag_q !== 1'b0) begin
            n_fail++; $display("FAIL reset_flag_q: got %b want 0", BranchConditionFlag_q);
        end
    endtask

    task automatic test_add_sub();
        drive(2'b00, R_OP, 3'b000, 1'b0, 32'd10, 32'd15);
        n_checks++;
        if (ALU_result !== 32'd25) begin
            n_fail++; $display("FAIL add: got %h want %h", ALU_result, 32'd25);
        end
        drive(2'b00, R_OP, 3'b000, 1'b1, 32'd15, 32'd10);
        n_checks++;
        if (ALU_result !== 32'd5) begin
            n_fail++; $display("FAIL sub: got %h want %h", ALU_result, 32'd5);
        end
        drive(2'b00, I_OP, 3'b000, 1'b1, 32'd15, 32'd10);
        n_checks++;
        if (ALU_result !== 32'd25) begin
            n_fail++; $display("FAIL addi_b30: got %h want %h", ALU_result, 32'd25);
        end
        drive(2'b00, R_OP, 3'b000, 1'b0, 32'h7FFFFFFF, 32'h1);
        n_checks++;
        if (ALU_result !== 32'h80000000) begin
            n_fail++; $display("FAIL add_wrap: got %h want %h", ALU_result, 32'h80000000);
        end
        drive(2'b00, R_OP, 3'b000, 1'b1, 32'h0, 32'h1);
        n_checks++;
        if (ALU_result !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL sub_wrap: got %h want %h", ALU_result, 32'hFFFFFFFF);
        end
    endtask

    task automatic test_logic();
        drive(2'b00, R_OP, 3'b111, 1'b0, 32'hFFFF00FF, 32'hFF00FFFF);
        n_checks++;
        if (ALU_result !== 32'hFF0000FF) begin
            n_fail++; $display("FAIL and: got %h want %h", ALU_result, 32'hFF0000FF);
        end
        drive(2'b00, R_OP, 3'b110, 1'b0, 32'hFFFF0000, 32'h0000FFFF);
        n_checks++;
        if (ALU_result !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL or: got %h want %h", ALU_result, 32'hFFFFFFFF);
        end
        drive(2'b00, R_OP, 3'b100, 1'b0, 32'hAAAA5555, 32'h5555AAAA);
        n_checks++;
        if (ALU_result !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL xor: got %h want %h", ALU_result, 32'hFFFFFFFF);
        end
        drive(2'b00, R_OP, 3'b100, 1'b0, 32'h12345678, 32'h0F0F0F0F);
        n_checks++;
        if (ALU_result !== 32'h1D3B5977) begin
            n_fail++; $display("FAIL xor_mixed: got %h want %h", ALU_result, 32'h1D3B5977);
        end
    endtask

    task automatic test_shift();
        drive(2'b00, R_OP, 3'b101, 1'b0, 32'hF0000000, 32'd4);
        n_checks++;
        if (ALU_result !== 32'h0F000000) begin
            n_fail++; $display("FAIL srl: got %h want %h", ALU_result, 32'h0F000000);
        end
        drive(2'b00, R_OP, 3'b101, 1'b1, 32'hF0000000, 32'd4);
        n_checks++;
        if (ALU_result !== 32'hFF000000) begin
            n_fail++; $display("FAIL sra: got %h want %h", ALU_result, 32'hFF000000);
        end
        drive(2'b00, I_OP, 3'b101, 1'b1, 32'h80000000, 32'd31);
        n_checks++;
        if (ALU_result !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL srai_31: got %h want %h", ALU_result, 32'hFFFFFFFF);
        end
        drive(2'b00, R_OP, 3'b001, 1'b0, 32'h1, 32'd8);
        n_checks++;
        if (ALU_result !== 32'h00000100) begin
            n_fail++; $display("FAIL sll: got %h want %h", ALU_result, 32'h00000100);
        end
        drive(2'b00, R_OP, 3'b001, 1'b0, 32'h1, 32'h24);
        n_checks++;
        if (ALU_result !== 32'h00000010) begin
            n_fail++; $display("FAIL sll_b24: got %h want %h", ALU_result, 32'h00000010);
        end
        drive(2'b00, R_OP, 3'b101, 1'b0, 32'h80000000, 32'd32);
        n_checks++;
        if (ALU_result !== 32'h80000000) begin
            n_fail++; $display("FAIL srl_b32: got %h want %h", ALU_result, 32'h80000000);
        end
    endtask

    task automatic test_compare();
        drive(2'b00, R_OP, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h1);
        n_checks++;
        if (ALU_result !== 32'h1) begin
            n_fail++; $display("FAIL slt_neg: got %h want %h", ALU_result, 32'h1);
        end
        drive(2'b00, R_OP, 3'b010, 1'b0, 32'h80000000, 32'h7FFFFFFF);
        n_checks++;
        if (ALU_result !== 32'h1) begin
            n_fail++; $display("FAIL slt_min: got %h want %h", ALU_result, 32'h1);
        end
        drive(2'b00, R_OP, 3'b010, 1'b0, 32'h5, 32'h5);
        n_checks++;
        if (ALU_result !== 32'h0) begin
            n_fail++; $display("FAIL slt_eq: got %h want %h", ALU_result, 32'h0);
        end
        drive(2'b00, R_OP, 3'b011, 1'b0, 32'h1, 32'hFFFFFFFF);
        n_checks++;
        if (ALU_result !== 32'h1) begin
            n_fail++; $display("FAIL sltu_lt: got %h want %h", ALU_result, 32'h1);
        end
        drive(2'b00, R_OP, 3'b011, 1'b0, 32'hFFFFFFFF, 32'h1);
        n_checks++;
        if (ALU_result !== 32'h0) begin
            n_fail++; $display("FAIL sltu_ge: got %h want %h", ALU_result, 32'h0);
        end
    endtask

    task automatic test_branch();
        logic [2:0]  f3_t[12]  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111,
                                   3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        logic [31:0] a_t[12]   = '{32'd42, 32'd42, 32'hFFFFFFFB, 32'd5, 32'd1, 32'hFFFFFFFF,
                                   32'd7, 32'd7, 32'd9, 32'd9, 32'd9, 32'd9};
        logic [31:0] b_t[12]   = '{32'd42, 32'd24, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd1,
                                   32'd7, 32'd3, 32'd9, 32'd9, 32'd9, 32'd9};
        logic        f_t[12]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] d_t[12]   = '{32'd0, 32'd18, 32'hFFFFFFF9, 32'd3, 32'd2, 32'hFFFFFFFE,
                                   32'd0, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 12; i++) begin
            drive(2'b01, B_OP, f3_t[i], 1'b0, a_t[i], b_t[i]);
            n_checks++;
            if (BranchConditionFlag !== f_t[i]) begin
                n_fail++;
                $display("FAIL branch_flag[%0d] f3=%b: got %b want %b", i, f3_t[i],
                         BranchConditionFlag, f_t[i]);
            end
            n_checks++;
            if (ALU_result !== d_t[i]) begin
                n_fail++;
                $display("FAIL branch_diff[%0d]: got %h want %h", i, ALU_result, d_t[i]);
            end
        end
        // BLT -5 vs 2 with true sign but opposite unsigned order; BLTU must not take it.
        drive(2'b01, B_OP, 3'b110, 1'b0, 32'hFFFFFFFB, 32'd2);
        n_checks++;
        if (BranchConditionFlag !== 1'b0) begin
            n_fail++; $display("FAIL bltu_neg: got %b want 0", BranchConditionFlag);
        end
        drive(2'b00, R_OP, 3'b000, 1'b0, 32'd42, 32'd42);
        n_checks++;
        if (BranchConditionFlag !== 1'b0) begin
            n_fail++; $display("FAIL flag_ctl00: got %b want 0", BranchConditionFlag);
        end
    endtask

    task automatic test_force_add_passb();
        drive(2'b10, R_OP, 3'b111, 1'b1, 32'h00001000, 32'h00000FFC);
        n_checks++;
        if (ALU_result !== 32'h00001FFC) begin
            n_fail++; $display("FAIL force_add: got %h want %h", ALU_result, 32'h00001FFC);
        end
        n_checks++;
        if (BranchConditionFlag !== 1'b0) begin
            n_fail++; $display("FAIL flag_ctl10: got %b want 0", BranchConditionFlag);
        end
        drive(2'b11, R_OP, 3'b001, 1'b0, 32'hDEADBEEF, 32'h12345000);
        n_checks++;
        if (ALU_result !== 32'h12345000) begin
            n_fail++; $display("FAIL pass_b: got %h want %h", ALU_result, 32'h12345000);
        end
    endtask

    task automatic test_registers();
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b00, R_OP, 3'b000, 1'b0, 32'd10, 32'd15);
        @(posedge clk);
        #1;
        n_checks++;
        if (ALU_result_q !== 32'd25) begin
            n_fail++; $display("FAIL reg_add: got %h want %h", ALU_result_q, 32'd25);
        end
        @(negedge clk);
        drive(2'b01, B_OP, 3'b000, 1'b0, 32'd42, 32'd42);
        @(posedge clk);
        #1;
        n_checks++;
        if (BranchConditionFlag_q !== 1'b1) begin
            n_fail++; $display("FAIL reg_flag: got %b want 1", BranchConditionFlag_q);
        end
        drive(2'b00, R_OP, 3'b000, 1'b0, 32'd1, 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ALU_result_q !== 32'h0) begin
            n_fail++; $display("FAIL reg_async_rst: got %h want %h", ALU_result_q, 32'h0);
        end
        n_checks++;
        if (BranchConditionFlag_q !== 1'b0) begin
            n_fail++; $display("FAIL reg_async_rst_flag: got %b want 0", BranchConditionFlag_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  c_t[4] = '{2'b00, 2'b11, 2'b10, 2'b00};
        logic [2:0]  f_t[4] = '{3'b110, 3'b000, 3'b011, 3'b001};
        logic [31:0] a_t[4] = '{32'hF0F00000, 32'h0, 32'hFFFFFFFF, 32'h3};
        logic [31:0] b_t[4] = '{32'h0000000F, 32'hCAFEF00D, 32'h2, 32'h1F};
        logic [31:0] e_t[4] = '{32'hF0F0000F, 32'hCAFEF00D, 32'h1, 32'h80000000};
        logic [31:0] exp_v;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(c_t[i], R_OP, f_t[i], 1'b0, a_t[i], b_t[i]);
            exp_q.push_back(e_t[i]);
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (ALU_result_q !== exp_v) begin
                n_fail++; $display("FAIL b2b[%0d]: got %h want %h", i, ALU_result_q, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic();
        test_shift();
        test_compare();
        test_branch();
        test_force_add_passb();
        test_registers();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
